// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD converter (serial double-dabble) feeding a time-multiplexed
// 4-digit scan bus for a single shared seven-segment decoder.
module bcd_display_scanner #(
   parameter int REFRESH_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_val,
   output logic        in_rdy,
   input  logic [13:0] in_bin,
   output logic        done,
   output logic        ovf,
   output logic [3:0]  digit,
   output logic [3:0]  digit_sel
);

   typedef enum logic {IDLE, CONV} state_t;

   localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_CYCLES - 1);
   localparam logic [13:0] MAX_VALUE    = 14'd9999;

   state_t      state;
   logic [29:0] shreg;       // [29:14] BCD accumulator, [13:0] binary bits still to shift
   logic [3:0]  bit_cnt;
   logic [15:0] disp;
   logic [15:0] refresh_cnt;
   logic [1:0]  scan_idx;
   logic [29:0] adj;
   logic [29:0] shifted;

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      adj = shreg;
      for (int i = 0; i < 4; i++) begin
         if (shreg[14 + 4*i +: 4] >= 4'd5)
            adj[14 + 4*i +: 4] = shreg[14 + 4*i +: 4] + 4'd3;
      end
      shifted = adj << 1;
   end

   // NOTE: reset is synchronous, and all register updates use non-blocking assignments.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         disp    <= '0;
         ovf     <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (in_val && in_rdy) begin
                  if (in_bin > MAX_VALUE) begin
                     disp <= 16'h9999;
                     ovf  <= 1'b1;
                     done <= 1'b1;
                  end else begin
                     shreg   <= {16'b0, in_bin};
                     bit_cnt <= 4'd14;
                     ovf     <= 1'b0;
                     state   <= CONV;
                  end
               end
            end
            CONV: begin
               shreg   <= shifted;
               bit_cnt <= bit_cnt - 4'd1;
               // Last shift: publish the whole result at once so the scan never sees partials.
               if (bit_cnt == 4'd1) begin
                  disp  <= shifted[29:14];
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Scan runs regardless of conversion activity.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         refresh_cnt <= '0;
         scan_idx    <= '0;
      end else if (refresh_cnt == REFRESH_LAST) begin
         refresh_cnt <= '0;
         scan_idx    <= scan_idx + 2'd1;
      end else begin
         refresh_cnt <= refresh_cnt + 16'd1;
      end
   end

   assign in_rdy    = (state == IDLE);
   assign digit_sel = 4'b0001 << scan_idx;
   assign digit     = disp[4*scan_idx +: 4];

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench: stimulus pushes expected results from a decimal-arithmetic
// model; a negedge monitor checks handshake, done timing, ovf and the digit scan.
module tb_bcd_display_scanner;

   localparam int R = 2;

   typedef struct {
      int value;
      bit ovf;
      int done_cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_val;
   logic        in_rdy;
   logic [13:0] in_bin;
   logic        done;
   logic        ovf;
   logic [3:0]  digit;
   logic [3:0]  digit_sel;

   bcd_display_scanner #(.REFRESH_CYCLES(R)) dut (
      .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy), .in_bin(in_bin),
      .done(done), .ovf(ovf), .digit(digit), .digit_sel(digit_sel)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   scan_n = 0;
   int   free_at = 0;
   int   disp_val = 0;
   bit   rst_sampled = 1'b1;
   bit   rst_seen = 1'b0;
   exp_t sb[$];
   exp_t e;
   bit   exp_done;
   int   idx;
   int   pow10[4] = '{1, 10, 100, 1000};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      rst_sampled = rst_n;
      if (rst_n !== 1'b1) scan_n = 0;
      else scan_n++;
   end

   // Monitor: everything sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_sampled !== 1'b1) begin
         rst_seen = 1'b1;
         sb.delete();
         disp_val = 0;
         check("reset_ovf", {31'b0, ovf}, 0);
      end
      if (rst_seen) begin
         exp_done = (sb.size() > 0) && (sb[0].done_cyc == cyc);
         check("done", {31'b0, done}, {31'b0, exp_done});
         if (exp_done) begin
            e = sb.pop_front();
            disp_val = e.value;
            check("ovf", {31'b0, ovf}, {31'b0, e.ovf});
         end
         check("in_rdy", {31'b0, in_rdy}, (cyc >= free_at) ? 1 : 0);
         idx = (scan_n / R) % 4;
         check("digit_sel", {28'b0, digit_sel}, 1 << idx);
         check("digit", {28'b0, digit}, (disp_val / pow10[idx]) % 10);
      end
   end

   // One cycle of stimulus; predicts acceptance from the readiness model.
   task automatic drive(input bit v, input int b, input bit r, output bit acc);
      in_val = v;
      in_bin = 14'(b);
      rst_n  = r;
      acc    = r && v && (cyc >= free_at);
      @(posedge clk);
      #1;
      if (!r) begin
         free_at = cyc;
      end else if (acc) begin
         if (b > 9999) begin
            sb.push_back('{9999, 1'b1, cyc});
            free_at = cyc;
         end else begin
            sb.push_back('{b, 1'b0, cyc + 14});
            free_at = cyc + 14;
         end
      end
   endtask

   task automatic idle(input int n);
      bit a;
      for (int k = 0; k < n; k++) drive(1'b0, 0, 1'b1, a);
   endtask

   task automatic send(input int v);
      bit a = 1'b0;
      for (int k = 0; k < 40 && !a; k++) drive(1'b1, v, 1'b1, a);
      check("accept_timeout", {31'b0, a}, 1);
   endtask

   initial begin
      bit a;
      rst_n  = 1'b0;
      in_val = 1'b0;
      in_bin = '0;
      drive(1'b0, 0, 1'b0, a);
      drive(1'b0, 0, 1'b0, a);
      idle(3);

      send(1234);  idle(24);
      send(0);     idle(18);
      send(9999);  idle(18);
      send(10000); idle(10);
      send(16383); idle(10);

      // Requests while busy must be dropped.
      send(5678);
      idle(2);
      drive(1'b1, 42, 1'b1, a);
      idle(9);
      drive(1'b1, 42, 1'b1, a);
      idle(4);
      send(42);    idle(18);

      // in_val held high across two requests.
      send(1111);
      send(2222);
      idle(24);

      // Reset seven cycles into a conversion.
      send(4321);
      idle(6);
      drive(1'b0, 0, 1'b0, a);
      idle(20);

      for (int i = 0; i < 3000; i++) begin
         int v;
         if ($urandom_range(0, 3) == 0) v = $urandom_range(9990, 10010);
         else v = $urandom_range(0, 16383);
         drive(1'(($urandom_range(0, 2) == 0)), v, 1'b1, a);
      end

      for (int k = 0; k < 50 && sb.size() > 0; k++) idle(1);
      check("drain", sb.size(), 0);
      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
